// File: rtl/dcache_write_buffer_pkg.sv
// Shared types for the data-cache eviction write buffer: entry layout,
// FSM encoding and line-address helpers.
package dcache_write_buffer_pkg;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int TAG_W            = 32 - LINE_OFFSET_BITS;
  localparam int LINE_W           = 256;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] line;
  } wb_entry_t;

  typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR, ACK} wb_state_t;

  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag);
    return {tag, {LINE_OFFSET_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/dcache_write_buffer_wb_entry_array.sv
// Circular store of buffered dirty lines with a parallel tag lookup,
// a write-at-index port (coalesce or allocate at tail) and a head pop.
module wb_entry_array
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [PTR_W-1:0]  hit_idx,
  output logic [LINE_W-1:0] hit_line,
  input  logic              wr_en,
  input  logic              wr_alloc,
  input  logic [PTR_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              pop,
  output wb_entry_t         head_entry,
  output logic [PTR_W-1:0]  tail,
  output logic [PTR_W:0]    count
);
  wb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) entries[wr_idx] <= '{valid: 1'b1, tag: wr_tag, line: wr_line};
      if (pop) begin
        entries[head].valid <= 1'b0;
        head <= head + PTR_W'(1);
      end
      if (wr_en && wr_alloc) tail <= tail + PTR_W'(1);
      count <= count + (PTR_W+1)'(wr_en && wr_alloc) - (PTR_W+1)'(pop);
    end
  end

  // Walk oldest to newest so the last match found is the newest one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (entries[idx].valid && entries[idx].tag == lookup_tag) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  assign hit_line   = entries[hit_idx].line;
  assign head_entry = entries[head];
endmodule

// File: rtl/dcache_write_buffer.sv
// Eviction write buffer between the D-cache memory port and the arbiter.
// All requests are serialized through IDLE; outputs are registered decodes.
module dcache_write_buffer
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dc_read,
  input  logic               dc_write,
  input  logic [31:0]        dc_address,
  input  logic [LINE_W-1:0]  dc_wdata,
  output logic               dc_resp,
  output logic [LINE_W-1:0]  dc_rdata,
  output logic               mem_read,
  output logic               mem_write,
  output logic [31:0]        mem_address,
  output logic [LINE_W-1:0]  mem_wdata,
  input  logic               mem_resp,
  input  logic [LINE_W-1:0]  mem_rdata
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_state_t         state, state_n;
  logic              hit;
  logic [PTR_W-1:0]  hit_idx, tail, wr_idx;
  logic [LINE_W-1:0] hit_line;
  logic [PTR_W:0]    count;
  wb_entry_t         head_entry;
  logic              wr_en, wr_alloc, pop, full;
  logic [TAG_W-1:0]  req_tag;
  logic              unused_bits;

  assign req_tag     = dc_address[31:LINE_OFFSET_BITS];
  assign full        = (count == (PTR_W+1)'(DEPTH));
  assign unused_bits = ^{dc_address[LINE_OFFSET_BITS-1:0], head_entry.valid};

  wb_entry_array #(.DEPTH(DEPTH)) u_array (
    .clk       (clk),
    .rst       (rst),
    .lookup_tag(req_tag),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .hit_line  (hit_line),
    .wr_en     (wr_en),
    .wr_alloc  (wr_alloc),
    .wr_idx    (wr_idx),
    .wr_tag    (req_tag),
    .wr_line   (dc_wdata),
    .pop       (pop),
    .head_entry(head_entry),
    .tail      (tail),
    .count     (count)
  );

  always_comb begin
    state_n  = state;
    wr_en    = 1'b0;
    wr_alloc = 1'b0;
    wr_idx   = tail;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (dc_write) begin
          if (hit) begin
            wr_en   = 1'b1;
            wr_idx  = hit_idx;
            state_n = ACK;
          end else if (!full) begin
            wr_en    = 1'b1;
            wr_alloc = 1'b1;
            state_n  = ACK;
          end else begin
            // Full: free the head first; the write is retried from IDLE.
            state_n = MEM_WR;
          end
        end else if (dc_read) begin
          state_n = hit ? ACK : MEM_RD;
        end else if (count != '0) begin
          state_n = MEM_WR;
        end
      end
      MEM_RD: if (mem_resp) state_n = ACK;
      MEM_WR: if (mem_resp) begin
        pop     = 1'b1;
        state_n = IDLE;
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dc_resp     <= 1'b0;
      dc_rdata    <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      state     <= state_n;
      dc_resp   <= (state_n == ACK);
      mem_read  <= (state_n == MEM_RD);
      mem_write <= (state_n == MEM_WR);
      if (state == IDLE && state_n == MEM_RD) begin
        mem_address <= line_addr(req_tag);
      end else if (state == IDLE && state_n == MEM_WR) begin
        mem_address <= line_addr(head_entry.tag);
        mem_wdata   <= head_entry.line;
      end
      if (state == IDLE && !dc_write && dc_read && hit) dc_rdata <= hit_line;
      else if (state == MEM_RD && mem_resp)              dc_rdata <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(dc_read && dc_write)) else $error("dc_read and dc_write asserted together");
  end
endmodule

// File: doc/dcache_write_buffer.md
# dcache_write_buffer

Eviction write buffer between the data cache's memory-side port and the memory arbiter. It absorbs dirty-line writebacks so a demand read miss reaches memory without waiting for the writeback. Buffered lines drain to memory when the bus is otherwise idle. Reads that hit a buffered line are serviced locally, which keeps the memory image coherent.

## Interface
- DEPTH, 4, number of 256-bit line entries; power of two, at least 2
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- dc_read  in  1  cache line read request; held until dc_resp
- dc_write  in  1  cache line writeback request; held until dc_resp
- dc_address  in  32  line address; bits [4:0] ignored
- dc_wdata  in  256  writeback line
- dc_resp  out  1  single-cycle completion pulse to the cache
- dc_rdata  out  256  read line; valid when dc_resp=1
- mem_read  out  1  read request to arbiter; held until mem_resp
- mem_write  out  1  write request to arbiter; held until mem_resp
- mem_address  out  32  line address to arbiter; bits [4:0]=0
- mem_wdata  out  256  line to arbiter
- mem_resp  in  1  arbiter completion pulse
- mem_rdata  in  256  arbiter read line; valid with mem_resp

## Operation
- Storage: circular FIFO of DEPTH entries, each holding {valid, tag[31:5], line[255:0]}.
  - head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is $clog2(DEPTH)+1 bits.
- FSM states: IDLE, MEM_RD, MEM_WR, ACK.
- Requests are sampled only in IDLE. Priority: dc_write or dc_read first, then drain.
- IDLE, dc_write, tag matches a valid entry: overwrite that entry's line in place (coalesce); count unchanged; go to ACK.
- IDLE, dc_write, no match, count<DEPTH: write at tail, tail++, count++; go to ACK.
- IDLE, dc_write, no match, full: go to MEM_WR to drain the head. The write stays pending and is re-evaluated in IDLE.
- IDLE, dc_read, tag matches: latch the matching line into dc_rdata; go to ACK. No memory access.
- IDLE, dc_read, no match: go to MEM_RD.
- IDLE, no request, count>0: go to MEM_WR (drain the head).
- MEM_RD: mem_read=1, mem_address={dc_address[31:5],5'b0}. On mem_resp, latch mem_rdata into dc_rdata and go to ACK.
- MEM_WR: mem_write=1, with head tag/line on mem_address/mem_wdata. On mem_resp, clear head valid, head++, count--, go to IDLE.
  - The head entry stays searchable until mem_resp.
- ACK: dc_resp=1 for exactly one cycle, then IDLE.
- mem_read and mem_write are never asserted together. dc_read and dc_write together is illegal; assert in simulation.
- An entry is never drained while a coalescing write to it is in progress, because all actions are serialized through IDLE.

## Timing
- Reset values:
  - dc_resp=0, dc_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0.
  - head=tail=count=0, all valid=0, state=IDLE.
- Reset mid-transaction discards all buffered lines. Requests drop the cycle after the reset edge.
- Write enqueue or coalesce: request sampled at cycle T, dc_resp at T+1.
- Read hit: sampled at T, dc_resp with data at T+1.
- Read miss: mem_read from T+1 until mem_resp at cycle R; dc_resp at R+1.
- Drain: mem_write from T+1 to R; IDLE at R+1.
  - A cache request arriving during a drain waits, at most one full memory write.
- Write while full: drain latency, then IDLE, then enqueue at IDLE+1 with dc_resp the following cycle.
- After dc_resp, the cache must not re-present the same request in the next cycle. A new request is permitted.
- All outputs are registered state decodes. There is no combinational path from mem_resp to dc_resp.

## Structure
- Shared package: wb_entry_t struct {valid, tag[26:0], line[255:0]} and localparam LINE_OFFSET_BITS=5.
- Sub-module wb_entry_array contains:
  - entry registers and pointers;
  - parallel tag compare, returning hit and hit_idx (newest match wins);
  - write-at-index and pop-head ports.
- The top level holds the FSM and output registers.

## Test plan
- Writeback 0x0000_1040, then read 0x0000_1040 -> dc_resp 1 cycle after each; the read returns the buffered line; mem_read never asserted.
- Read miss 0x0000_2000 with buffer empty -> mem_read at T+1 with address 0x0000_2000; mem_rdata 0xA5..A5 returned with dc_resp one cycle after mem_resp.
- Five writebacks to distinct lines, DEPTH=4, with the arbiter stalled -> first four ack in 1 cycle; the fifth triggers a drain of the first line and is acked after mem_resp.
- Two writebacks to 0x0000_3000 with different data -> count=1; the eventual drain writes the second data only.
- Three buffered lines, no cache traffic -> three sequential mem_write bursts in FIFO order; count reaches 0.
- rst asserted during MEM_WR -> mem_write=0 and count=0 next cycle; a later read of that address goes to memory.
